issue_scoreboard_ctrl: RTL and testbench

//  Issue controller between the decode stage and the AGEX latch of the 5-stage RISC-V pipe.
//  - Keeps a per-register pending-writer scoreboard that replaces the AGEX/MEM/WB

---
 rtl/issue_scoreboard_ctrl.sv | 141 ++++++++++++++
 tb/tb_issue_scoreboard_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard_ctrl.sv
// Issue controller between decode and AGEX. It keeps a per-register pending-writer
// scoreboard, sequences the multi-cycle MUL unit, and raises decode stall/issue.
module issue_scoreboard_ctrl #(
  parameter int NREGS     = 32,
  parameter int REGNOBITS = 5,
  parameter int CNTBITS   = 2,
  parameter int MUL_LAT   = 4,
  parameter int DBITS     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dec_valid,
  input  logic [REGNOBITS-1:0] dec_rs1,
  input  logic                 dec_rs1_rd,
  input  logic [REGNOBITS-1:0] dec_rs2,
  input  logic                 dec_rs2_rd,
  input  logic [REGNOBITS-1:0] dec_rd,
  input  logic                 dec_wr,
  input  logic                 dec_is_mul,
  input  logic                 wb_valid,
  input  logic [REGNOBITS-1:0] wb_rd,
  input  logic                 sq_valid,
  input  logic [REGNOBITS-1:0] sq_rd,
  input  logic                 mul_abort,
  output logic                 stall,
  output logic                 issue,
  output logic [NREGS-1:0]     busy_vec,
  output logic                 mul_busy,
  output logic [DBITS-1:0]     stall_cnt
);

  localparam logic [CNTBITS-1:0] CMAX = '1;
  localparam int MW = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;
  localparam logic [MW-1:0] MLOAD = MW'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);

  typedef enum logic {M_IDLE, M_BUSY} mstate_t;

  mstate_t              mstate, mstate_nxt;
  logic [MW-1:0]        mcnt, mcnt_nxt;
  logic [CNTBITS-1:0]   cnt     [NREGS];
  logic [CNTBITS-1:0]   cnt_nxt [NREGS];
  logic [NREGS-1:0]     wb_hit, sq_hit, wr_hit;
  logic [NREGS-1:0]     eff_busy, eff_full, underflow;
  logic                 raw, waw;

  // Handshake: decode presents an instruction with dec_valid; it is accepted on any
  // cycle where issue = dec_valid & ~stall, and decode holds it unchanged otherwise.

  always_comb begin
    wb_hit = '0;
    sq_hit = '0;
    for (int r = 1; r < NREGS; r++) begin
      wb_hit[r] = wb_valid && (wb_rd == REGNOBITS'(r));
      sq_hit[r] = sq_valid && (sq_rd == REGNOBITS'(r));
    end
  end

  // A same-cycle WB already frees its slot, so it also relieves the full-counter stall.
  always_comb begin
    eff_busy = '0;
    eff_full = '0;
    for (int r = 1; r < NREGS; r++) begin
      eff_busy[r] = cnt[r] > CNTBITS'(wb_hit[r]);
      eff_full[r] = (cnt[r] == CMAX) && !wb_hit[r];
    end
  end

  assign raw   = (dec_rs1_rd && eff_busy[dec_rs1]) || (dec_rs2_rd && eff_busy[dec_rs2]);
  assign waw   = dec_wr && eff_full[dec_rd];
  assign stall = dec_valid && (raw || waw || mul_busy);
  assign issue = dec_valid && !stall;

  always_comb begin
    int unsigned up, dn;
    up        = 0;
    dn        = 0;
    wr_hit    = '0;
    underflow = '0;
    cnt_nxt[0] = '0;
    for (int r = 1; r < NREGS; r++) begin
      wr_hit[r] = issue && dec_wr && (dec_rd == REGNOBITS'(r));
      up = int'(cnt[r]) + int'(wr_hit[r]);
      dn = int'(wb_hit[r]) + int'(sq_hit[r]);
      if (dn > up) begin
        cnt_nxt[r]   = '0;
        underflow[r] = 1'b1;
      end else begin
        cnt_nxt[r] = CNTBITS'(up - dn);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
    end else begin
      assert (underflow == '0);
      for (int r = 0; r < NREGS; r++) cnt[r] <= cnt_nxt[r];
    end
  end

  always_comb begin
    for (int r = 0; r < NREGS; r++) busy_vec[r] = (cnt[r] != '0);
  end

  always_comb begin
    mstate_nxt = mstate;
    mcnt_nxt   = mcnt;
    case (mstate)
      M_IDLE: begin
        if (issue && dec_is_mul && (MUL_LAT > 1)) begin
          mstate_nxt = M_BUSY;
          mcnt_nxt   = MLOAD;
        end
      end
      M_BUSY: begin
        if (mul_abort || (mcnt == '0)) mstate_nxt = M_IDLE;
        else mcnt_nxt = mcnt - 1'b1;
      end
      default: mstate_nxt = M_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mstate <= M_IDLE;
      mcnt   <= '0;
    end else begin
      mstate <= mstate_nxt;
      mcnt   <= mcnt_nxt;
    end
  end

  assign mul_busy = (mstate == M_BUSY);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_cnt <= '0;
    else if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_issue_scoreboard_ctrl.sv
// Directed bench for issue_scoreboard_ctrl: RAW, full-counter, MUL occupancy,
// squash, x0 and asynchronous reset scenarios with hand-computed expectations.
module tb_issue_scoreboard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        dec_valid, dec_rs1_rd, dec_rs2_rd, dec_wr, dec_is_mul;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd, wb_rd, sq_rd;
  logic        wb_valid, sq_valid, mul_abort;
  logic        stall, issue, mul_busy;
  logic [31:0] busy_vec;
  logic [31:0] stall_cnt;

  int total = 0;
  int bad   = 0;
  int exp_sc = 0;

  issue_scoreboard_ctrl dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs1_rd(dec_rs1_rd),
    .dec_rs2(dec_rs2), .dec_rs2_rd(dec_rs2_rd), .dec_rd(dec_rd), .dec_wr(dec_wr),
    .dec_is_mul(dec_is_mul), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .sq_valid(sq_valid), .sq_rd(sq_rd), .mul_abort(mul_abort),
    .stall(stall), .issue(issue), .busy_vec(busy_vec), .mul_busy(mul_busy),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want finish before 200000");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    dec_valid = 0; dec_rs1 = 0; dec_rs1_rd = 0; dec_rs2 = 0; dec_rs2_rd = 0;
    dec_rd = 0; dec_wr = 0; dec_is_mul = 0;
    wb_valid = 0; wb_rd = 0; sq_valid = 0; sq_rd = 0; mul_abort = 0;
  endtask

  task automatic test_reset;
    reset = 0;
    idle();
    dec_valid = 1; dec_rs1 = 5; dec_rs1_rd = 1;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", stall); end
    total++; if (issue !== 1'b1) begin bad++; $display("FAIL rst_issue: got %b want 1", issue); end
    total++; if (busy_vec !== 32'h0) begin bad++; $display("FAIL rst_busy_vec: got %h want 0", busy_vec); end
    total++; if (mul_busy !== 1'b0) begin bad++; $display("FAIL rst_mul_busy: got %b want 0", mul_busy); end
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL rst_stall_cnt: got %0d want 0", stall_cnt); end
    idle();
    tick(); tick();
    reset = 1;
    tick();
  endtask

  task automatic test_raw;
    idle(); dec_valid = 1; dec_rd = 5; dec_wr = 1;
    #1;
    total++; if (issue !== 1'b1) begin bad++; $display("FAIL raw_writer_issue: got %b want 1", issue); end
    tick();
    idle(); dec_valid = 1; dec_rs1 = 5; dec_rs1_rd = 1;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL raw_stall1: got %b want 1", stall); end
    total++; if (busy_vec[5] !== 1'b1) begin bad++; $display("FAIL raw_busy5: got %b want 1", busy_vec[5]); end
    tick();
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL raw_stall2: got %b want 1", stall); end
    tick();
    wb_valid = 1; wb_rd = 5;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL raw_wb_stall: got %b want 0", stall); end
    total++; if (issue !== 1'b1) begin bad++; $display("FAIL raw_wb_issue: got %b want 1", issue); end
    total++; if (busy_vec[5] !== 1'b1) begin bad++; $display("FAIL raw_busy5_wbcycle: got %b want 1", busy_vec[5]); end
    tick();
    idle();
    #1;
    total++; if (busy_vec[5] !== 1'b0) begin bad++; $display("FAIL raw_busy5_clear: got %b want 0", busy_vec[5]); end
    exp_sc += 2;
    total++; if (stall_cnt !== exp_sc) begin bad++; $display("FAIL raw_stall_cnt: got %0d want %0d", stall_cnt, exp_sc); end
  endtask

  task automatic test_waw;
    for (int i = 0; i < 3; i++) begin
      idle(); dec_valid = 1; dec_rd = 7; dec_wr = 1;
      #1;
      total++; if (issue !== 1'b1) begin bad++; $display("FAIL waw_issue%0d: got %b want 1", i, issue); end
      tick();
    end
    idle(); dec_valid = 1; dec_rd = 7; dec_wr = 1;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL waw_full_stall: got %b want 1", stall); end
    tick();
    wb_valid = 1; wb_rd = 7;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL waw_wb_stall: got %b want 0", stall); end
    total++; if (issue !== 1'b1) begin bad++; $display("FAIL waw_wb_issue: got %b want 1", issue); end
    tick();
    idle();
    #1;
    total++; if (busy_vec[7] !== 1'b1) begin bad++; $display("FAIL waw_busy7: got %b want 1", busy_vec[7]); end
    for (int i = 0; i < 3; i++) begin
      idle(); wb_valid = 1; wb_rd = 7;
      tick();
    end
    idle();
    #1;
    total++; if (busy_vec !== 32'h0) begin bad++; $display("FAIL waw_drain: got %h want 0", busy_vec); end
    exp_sc += 1;
    total++; if (stall_cnt !== exp_sc) begin bad++; $display("FAIL waw_stall_cnt: got %0d want %0d", stall_cnt, exp_sc); end
  endtask

  task automatic test_mul;
    idle(); dec_valid = 1; dec_is_mul = 1; dec_rd = 10; dec_wr = 1; dec_rs1 = 1; dec_rs1_rd = 1;
    #1;
    total++; if (issue !== 1'b1) begin bad++; $display("FAIL mul_issue: got %b want 1", issue); end
    tick();
    for (int k = 1; k <= 3; k++) begin
      idle(); dec_valid = 1; dec_rd = 11; dec_wr = 1; dec_rs1 = 2; dec_rs1_rd = 1;
      #1;
      total++; if (mul_busy !== 1'b1) begin bad++; $display("FAIL mul_busy_t%0d: got %b want 1", k, mul_busy); end
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL mul_stall_t%0d: got %b want 1", k, stall); end
      tick();
    end
    idle(); dec_valid = 1; dec_rd = 11; dec_wr = 1; dec_rs1 = 2; dec_rs1_rd = 1;
    #1;
    total++; if (mul_busy !== 1'b0) begin bad++; $display("FAIL mul_busy_t4: got %b want 0", mul_busy); end
    total++; if (issue !== 1'b1) begin bad++; $display("FAIL mul_add_issue_t4: got %b want 1", issue); end
    tick();
    idle(); wb_valid = 1; wb_rd = 10;
    tick();
    idle(); wb_valid = 1; wb_rd = 11;
    tick();
    idle();
    #1;
    total++; if (busy_vec !== 32'h0) begin bad++; $display("FAIL mul_drain: got %h want 0", busy_vec); end
    exp_sc += 3;
    total++; if (stall_cnt !== exp_sc) begin bad++; $display("FAIL mul_stall_cnt: got %0d want %0d", stall_cnt, exp_sc); end
    // abort shortens occupancy to a single cycle
    idle(); dec_valid = 1; dec_is_mul = 1;
    tick();
    idle();
    #1;
    total++; if (mul_busy !== 1'b1) begin bad++; $display("FAIL abort_busy: got %b want 1", mul_busy); end
    mul_abort = 1;
    tick();
    idle();
    #1;
    total++; if (mul_busy !== 1'b0) begin bad++; $display("FAIL abort_idle: got %b want 0", mul_busy); end
  endtask

  task automatic test_squash;
    for (int i = 0; i < 2; i++) begin
      idle(); dec_valid = 1; dec_rd = 9; dec_wr = 1;
      tick();
    end
    idle(); sq_valid = 1; sq_rd = 9; wb_valid = 1; wb_rd = 9;
    dec_valid = 1; dec_rs1 = 9; dec_rs1_rd = 1;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL sq_same_cycle_stall: got %b want 1", stall); end
    tick();
    idle(); dec_valid = 1; dec_rs1 = 9; dec_rs1_rd = 1;
    #1;
    total++; if (busy_vec[9] !== 1'b0) begin bad++; $display("FAIL sq_busy9: got %b want 0", busy_vec[9]); end
    total++; if (issue !== 1'b1) begin bad++; $display("FAIL sq_reader_issue: got %b want 1", issue); end
    tick();
    idle();
    exp_sc += 1;
    #1;
    total++; if (stall_cnt !== exp_sc) begin bad++; $display("FAIL sq_stall_cnt: got %0d want %0d", stall_cnt, exp_sc); end
  endtask

  task automatic test_x0;
    for (int i = 0; i < 5; i++) begin
      idle(); dec_valid = 1; dec_rd = 0; dec_wr = 1;
      dec_rs1 = 0; dec_rs1_rd = 1; dec_rs2 = 0; dec_rs2_rd = 1;
      #1;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL x0_stall%0d: got %b want 0", i, stall); end
      tick();
    end
    idle();
    #1;
    total++; if (busy_vec !== 32'h0) begin bad++; $display("FAIL x0_busy_vec: got %h want 0", busy_vec); end
  endtask

  task automatic test_async_reset;
    idle(); dec_valid = 1; dec_is_mul = 1; dec_rd = 12; dec_wr = 1;
    tick();
    idle();
    #1;
    total++; if (mul_busy !== 1'b1) begin bad++; $display("FAIL ar_mul_busy: got %b want 1", mul_busy); end
    total++; if (busy_vec[12] !== 1'b1) begin bad++; $display("FAIL ar_busy12: got %b want 1", busy_vec[12]); end
    #2;
    reset = 0;
    #1;
    total++; if (mul_busy !== 1'b0) begin bad++; $display("FAIL ar_mul_busy_rst: got %b want 0", mul_busy); end
    total++; if (busy_vec !== 32'h0) begin bad++; $display("FAIL ar_busy_vec_rst: got %h want 0", busy_vec); end
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL ar_stall_cnt_rst: got %0d want 0", stall_cnt); end
    exp_sc = 0;
    tick();
    reset = 1;
    tick();
    idle(); dec_valid = 1; dec_rs1 = 12; dec_rs1_rd = 1;
    #1;
    total++; if (issue !== 1'b1) begin bad++; $display("FAIL ar_reader_issue: got %b want 1", issue); end
    tick();
    idle();
  endtask

  initial begin
    test_reset();
    test_raw();
    test_waw();
    test_mul();
    test_squash();
    test_x0();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
